mul_control: RTL and testbench

- Control FSM for a sequential shift-and-add multiplier. The datapath holds an accumulator/multiplier register and a step counter.
- The FSM sequences load, add and shift micro-operations, using the current multiplier LSB (M) and the counter terminal flag (k).
- It raises Idle while waiting for a start and Done for one cycle at completion.

---
 rtl/mul_control.sv | 75 +++++++
 tb/tb_mul_control.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mul_control.sv
// Control FSM for a sequential shift-and-add multiplier: sequences load, add and shift
// micro-operations from the multiplier LSB (M) and the counter terminal flag (k).
module mul_control (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       St,
    input  logic       k,
    input  logic       M,
    output logic       Idle,
    output logic       Done,
    output logic       Load,
    output logic       Sh,
    output logic       Ad,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StTest  = 2'b01,
        StShift = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        Idle    = 1'b0;
        Done    = 1'b0;
        Load    = 1'b0;
        Sh      = 1'b0;
        Ad      = 1'b0;
        unique case (state_q)
            StIdle: begin
                Idle = 1'b1;
                if (St) begin
                    Load    = 1'b1;
                    state_d = StTest;
                end
            end
            StTest: begin
                if (M) begin
                    Ad      = 1'b1;
                    state_d = StShift;
                end else begin
                    // Zero bit: shift in place; leave only once the last bit is consumed.
                    Sh      = 1'b1;
                    state_d = k ? StDone : StTest;
                end
            end
            StShift: begin
                Sh      = 1'b1;
                state_d = k ? StDone : StTest;
            end
            StDone: begin
                Done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_mul_control.sv
// Directed self-checking bench for mul_control: reset, start, add/shift paths, a full
// 4-bit multiply of 1101, restart with St held high, and asynchronous abort from S2.
module tb_mul_control;

    logic       Clk;
    logic       Rst_n;
    logic       St;
    logic       k;
    logic       M;
    logic       Idle;
    logic       Done;
    logic       Load;
    logic       Sh;
    logic       Ad;
    logic [1:0] State;

    int checks;
    int failures;
    int ad_cnt;
    int sh_cnt;
    int cyc_cnt;

    mul_control u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .St    (St),
        .k     (k),
        .M     (M),
        .Idle  (Idle),
        .Done  (Done),
        .Load  (Load),
        .Sh    (Sh),
        .Ad    (Ad),
        .State (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-cycle, then check {State, Idle, Done, Load, Sh, Ad} before the next edge.
    task automatic cyc(input string tag, input logic st_v, input logic m_v, input logic k_v,
                       input logic [6:0] exp);
        @(negedge Clk);
        St = st_v;
        M  = m_v;
        k  = k_v;
        #1;
        check_eq(tag, {25'd0, State, Idle, Done, Load, Sh, Ad}, {25'd0, exp});
        ad_cnt  += int'(Ad);
        sh_cnt  += int'(Sh);
        cyc_cnt++;
    endtask

    //                          State  I  D  L  S  A
    localparam logic [6:0] E_S0    = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [6:0] E_S0_LD = {2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [6:0] E_S1_AD = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [6:0] E_S1_SH = {2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [6:0] E_S2    = {2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [6:0] E_S3    = {2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        checks   = 0;
        failures = 0;
        ad_cnt   = 0;
        sh_cnt   = 0;
        cyc_cnt  = 0;
        Rst_n    = 1'b0;
        St       = 1'b0;
        M        = 1'b0;
        k        = 1'b0;

        // Reset held across edges
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_outputs", {25'd0, State, Idle, Done, Load, Sh, Ad}, {25'd0, E_S0});
        St = 1'b1;
        #1;
        check_eq("rst_load_follows_st", {31'd0, Load}, 32'd1);
        St = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;

        cyc("post_rst_idle", 1'b0, 1'b1, 1'b1, E_S0);
        cyc("post_rst_stay", 1'b0, 1'b0, 1'b0, E_S0);

        // Start, add path, shift path, done
        cyc("start_load",    1'b1, 1'b0, 1'b0, E_S0_LD);
        cyc("add_s1",        1'b0, 1'b1, 1'b0, E_S1_AD);
        cyc("shift_s2",      1'b0, 1'b1, 1'b0, E_S2);
        cyc("s1_shift_stay", 1'b0, 1'b0, 1'b0, E_S1_SH);
        cyc("s1_shift_last", 1'b1, 1'b0, 1'b1, E_S1_SH);
        cyc("done_s3",       1'b0, 1'b0, 1'b0, E_S3);
        cyc("back_idle",     1'b0, 1'b0, 1'b0, E_S0);

        // Full multiply, multiplier 1101 LSB first: M = 1,0,1,1
        cyc("mul_start", 1'b1, 1'b0, 1'b0, E_S0_LD);
        ad_cnt  = 0;
        sh_cnt  = 0;
        cyc_cnt = 0;
        cyc("mul_b0_add",   1'b0, 1'b1, 1'b0, E_S1_AD);
        cyc("mul_b0_sh",    1'b0, 1'b0, 1'b0, E_S2);
        cyc("mul_b1_sh",    1'b0, 1'b0, 1'b0, E_S1_SH);
        cyc("mul_b2_add",   1'b0, 1'b1, 1'b0, E_S1_AD);
        cyc("mul_b2_sh",    1'b0, 1'b1, 1'b0, E_S2);
        cyc("mul_b3_add",   1'b0, 1'b1, 1'b1, E_S1_AD);
        cyc("mul_b3_sh",    1'b0, 1'b0, 1'b1, E_S2);
        // St held high through Done must be ignored in S3, then restart from S0
        cyc("mul_done",     1'b1, 1'b1, 1'b1, E_S3);
        check_eq("mul_cycles", cyc_cnt, 32'd8);
        check_eq("mul_ad_cnt", ad_cnt, 32'd3);
        check_eq("mul_sh_cnt", sh_cnt, 32'd4);
        cyc("restart_load", 1'b1, 1'b0, 1'b0, E_S0_LD);

        // Enter S2, then abort asynchronously between edges
        cyc("abort_add", 1'b0, 1'b1, 1'b0, E_S1_AD);
        cyc("abort_s2",  1'b0, 1'b0, 1'b0, E_S2);
        #1;
        Rst_n = 1'b0;
        #1;
        check_eq("abort_state", {30'd0, State}, 32'd0);
        check_eq("abort_idle_done", {30'd0, Idle, Done}, 32'd2);
        #1;
        Rst_n = 1'b1;
        cyc("abort_after_edge", 1'b0, 1'b0, 1'b1, E_S0);
        cyc("abort_no_done",    1'b0, 1'b0, 1'b0, E_S0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
